// File: rtl/aso_pkg.sv
// Shared Avalon-ST packet-bus definitions: bus widths, the packed beat
// record, and the arbiter state encoding.
package aso_pkg;

  localparam int AST_DATA_W  = 64;
  localparam int AST_EMPTY_W = 3;
  localparam int AST_ERR_W   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  // One beat of the packet bus, everything except valid/ready/channel.
  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [AST_EMPTY_W-1:0] empty;
    logic [AST_ERR_W-1:0]   error;
    logic [AST_DATA_W-1:0]  data;
  } ast_beat_t;

  // Round-robin pick between two SOP requesters; prio=1 favours B on a tie.
  function automatic logic pick_b(input logic i_req_a, input logic i_req_b,
                                  input logic i_prio);
    return i_req_b & (~i_req_a | i_prio);
  endfunction

endpackage

// File: rtl/aso_out_reg.sv
// One-stage registered Avalon-ST output slice. Reports "space" so the
// upstream can load a new beat in the same cycle the held one drains.
module aso_out_reg
  import aso_pkg::*;
(
  input  logic      clk_in,
  input  logic      reset_n,
  input  logic      i_load,
  input  ast_beat_t i_beat,
  input  logic      i_channel,
  input  logic      i_ready,
  output logic      o_valid,
  output ast_beat_t o_beat,
  output logic      o_channel,
  output logic      o_space
);

  logic      r_valid;
  ast_beat_t r_beat;
  logic      r_channel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_beat    <= '0;
      r_channel <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_beat    <= i_beat;
      r_channel <= i_channel;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  // Fields only change on a load, and a load only happens with space, so
  // a stalled beat stays stable.
  assign o_space   = ~r_valid | i_ready;
  assign o_valid   = r_valid;
  assign o_beat    = r_beat;
  assign o_channel = r_channel;

endmodule

// File: rtl/aso_pkt_arbiter2.sv
// Two-input packet-atomic round-robin arbiter for the 64-bit Avalon-ST bus,
// with per-input packet counters and sticky protocol-error flags.
module aso_pkt_arbiter2
  import aso_pkg::*;
#(
  parameter int   CNT_W     = 16,
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic                   clk_in,
  input  logic                   reset_n,

  input  logic [AST_DATA_W-1:0]  asi_a_data,
  input  logic                   asi_a_valid,
  output logic                   asi_a_ready,
  input  logic                   asi_a_sop,
  input  logic                   asi_a_eop,
  input  logic [AST_EMPTY_W-1:0] asi_a_empty,
  input  logic [AST_ERR_W-1:0]   asi_a_error,

  input  logic [AST_DATA_W-1:0]  asi_b_data,
  input  logic                   asi_b_valid,
  output logic                   asi_b_ready,
  input  logic                   asi_b_sop,
  input  logic                   asi_b_eop,
  input  logic [AST_EMPTY_W-1:0] asi_b_empty,
  input  logic [AST_ERR_W-1:0]   asi_b_error,

  output logic [AST_DATA_W-1:0]  aso_out_data,
  output logic                   aso_out_valid,
  input  logic                   aso_out_ready,
  output logic                   aso_out_sop,
  output logic                   aso_out_eop,
  output logic [AST_EMPTY_W-1:0] aso_out_empty,
  output logic [AST_ERR_W-1:0]   aso_out_error,
  output logic                   aso_out_channel,

  output logic [CNT_W-1:0]       pktcount_a,
  output logic [CNT_W-1:0]       pktcount_b,
  output logic [1:0]             err_orphan,
  output logic [1:0]             err_dupsop
);

  arb_state_t       r_state;
  logic             r_prio;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [1:0]       r_err_orphan;
  logic [1:0]       r_err_dupsop;

  logic      w_space;
  logic      w_req_a, w_req_b;
  logic      w_gnt_a, w_gnt_b;
  logic      w_rdy_a, w_rdy_b;
  logic      w_fwd_a, w_fwd_b;
  logic      w_drop_a, w_drop_b;
  logic      w_load;
  ast_beat_t w_beat_a, w_beat_b, w_beat_sel, w_out_beat;

  assign w_beat_a = {asi_a_sop, asi_a_eop, asi_a_empty, asi_a_error, asi_a_data};
  assign w_beat_b = {asi_b_sop, asi_b_eop, asi_b_empty, asi_b_error, asi_b_data};

  assign w_req_a = asi_a_valid & asi_a_sop;
  assign w_req_b = asi_b_valid & asi_b_sop;

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_b = pick_b(w_req_a, w_req_b, r_prio);
        w_gnt_a = w_req_a & ~w_gnt_b;
      end
      LOCK_A:  w_gnt_a = 1'b1;
      LOCK_B:  w_gnt_b = 1'b1;
      default: ;
    endcase
  end

  // A non-granted mid-packet beat is swallowed; readys are forced low in reset.
  assign w_rdy_a = reset_n & (w_gnt_a ? w_space : (asi_a_valid & ~asi_a_sop));
  assign w_rdy_b = reset_n & (w_gnt_b ? w_space : (asi_b_valid & ~asi_b_sop));

  assign w_fwd_a  = asi_a_valid & w_rdy_a &  w_gnt_a;
  assign w_fwd_b  = asi_b_valid & w_rdy_b &  w_gnt_b;
  assign w_drop_a = asi_a_valid & w_rdy_a & ~w_gnt_a;
  assign w_drop_b = asi_b_valid & w_rdy_b & ~w_gnt_b;

  assign w_load     = w_fwd_a | w_fwd_b;
  assign w_beat_sel = w_gnt_b ? w_beat_b : w_beat_a;

  aso_out_reg u_out_reg (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_beat    (w_beat_sel),
    .i_channel (w_gnt_b),
    .i_ready   (aso_out_ready),
    .o_valid   (aso_out_valid),
    .o_beat    (w_out_beat),
    .o_channel (aso_out_channel),
    .o_space   (w_space)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_prio  <= INIT_PRIO;
    end else begin
      case (r_state)
        IDLE: begin
          // A single-beat packet releases immediately and only flips priority.
          if (w_fwd_a) begin
            if (asi_a_eop) r_prio  <= 1'b1;
            else           r_state <= LOCK_A;
          end else if (w_fwd_b) begin
            if (asi_b_eop) r_prio  <= 1'b0;
            else           r_state <= LOCK_B;
          end
        end
        LOCK_A: begin
          if (w_fwd_a && asi_a_eop) begin
            r_state <= IDLE;
            r_prio  <= 1'b1;
          end
        end
        LOCK_B: begin
          if (w_fwd_b && asi_b_eop) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_a      <= '0;
      r_cnt_b      <= '0;
      r_err_orphan <= '0;
      r_err_dupsop <= '0;
    end else begin
      if (w_fwd_a && asi_a_eop) r_cnt_a <= r_cnt_a + CNT_W'(1);
      if (w_fwd_b && asi_b_eop) r_cnt_b <= r_cnt_b + CNT_W'(1);
      r_err_orphan <= r_err_orphan | {w_drop_b, w_drop_a};
      // An SOP already inside the lock is a restart attempt, not a new grant.
      r_err_dupsop <= r_err_dupsop |
                      {w_fwd_b & asi_b_sop & (r_state == LOCK_B),
                       w_fwd_a & asi_a_sop & (r_state == LOCK_A)};
    end
  end

  assign asi_a_ready   = w_rdy_a;
  assign asi_b_ready   = w_rdy_b;
  assign aso_out_data  = w_out_beat.data;
  assign aso_out_sop   = w_out_beat.sop;
  assign aso_out_eop   = w_out_beat.eop;
  assign aso_out_empty = w_out_beat.empty;
  assign aso_out_error = w_out_beat.error;
  assign pktcount_a    = r_cnt_a;
  assign pktcount_b    = r_cnt_b;
  assign err_orphan    = r_err_orphan;
  assign err_dupsop    = r_err_dupsop;

endmodule

// File: doc/aso_pkt_arbiter2.md
Name: aso_pkt_arbiter2

Overview:
- Two-input, packet-atomic round-robin arbiter for the 64-bit Avalon-ST packet bus (8 bytes/beat, byte 0 in data[63:56], 3-bit empty, 6-bit error).
- Merges two MAC/TB streams onto one stream, so a single capture writer or downstream consumer can observe both.
- Holds a grant from the SOP beat through the EOP beat. Output is one registered stage. Keeps per-input packet counters and sticky protocol-error flags.

Parameters:
- CNT_W, 16, width of per-input packet counters (wrap modulo 2^CNT_W)
- INIT_PRIO, 0, input (0=A, 1=B) preferred for the first arbitration after reset

Ports:
- clk_in  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- asi_a_data  in  64  input A data
- asi_a_valid  in  1  input A valid
- asi_a_ready  out  1  input A ready (readyLatency 0)
- asi_a_sop  in  1  input A startofpacket
- asi_a_eop  in  1  input A endofpacket
- asi_a_empty  in  3  input A empty (meaningful on EOP only)
- asi_a_error  in  6  input A error
- asi_b_*  (same seven signals as asi_a_*)  input B
- aso_out_data  out  64  merged data
- aso_out_valid  out  1  merged valid
- aso_out_ready  in  1  downstream ready
- aso_out_sop  out  1  merged startofpacket
- aso_out_eop  out  1  merged endofpacket
- aso_out_empty  out  3  merged empty
- aso_out_error  out  6  merged error
- aso_out_channel  out  1  source of the current beat (0=A, 1=B)
- pktcount_a  out  CNT_W  packets forwarded from A
- pktcount_b  out  CNT_W  packets forwarded from B
- err_orphan  out  2  sticky; bit p = input p presented a non-SOP beat while not granted
- err_dupsop  out  2  sticky; bit p = input p presented SOP mid-packet

Behaviour:
- Transfer rules:
  - Input transfer occurs when valid & ready.
  - Output transfer occurs when aso_out_valid & aso_out_ready.
  - space = ~aso_out_valid | aso_out_ready.
- Reset (async assert, sync deassert by the source):
  - state=IDLE, prio=INIT_PRIO, aso_out_valid=0.
  - All other out_* registers 0; counters 0; err flags 0.
  - Both ready outputs 0 while reset_n=0.
- State machine: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - req_p = asi_p_valid & asi_p_sop.
  - pick = the only requester, or prio if both request.
  - The picked input's ready = space, so the SOP beat passes in the same cycle with no bubble.
  - On the SOP transfer: if it is not EOP, go to LOCK_pick. If it is SOP&EOP (single beat), stay IDLE.
- LOCK_p:
  - ready_p = space; the other input's ready = 0, unless its orphan discard rule below applies.
  - On the EOP transfer from p: go to IDLE and set prio = ~p.
- prio also updates to ~p on a single-beat packet from p.
- Orphan discard: an input that is not granted, with valid=1 and sop=0, gets ready=1. The beat is consumed and dropped, and err_orphan[p] is set. This applies in IDLE and while the other input holds the lock.
- Duplicate SOP: while in LOCK_p, a transferred beat from p with sop=1 is forwarded unchanged, sets err_dupsop[p], and does not restart arbitration.
- Output register:
  - On an input transfer, load data/sop/eop/empty/error/channel and set aso_out_valid=1.
  - Else on an output transfer, clear aso_out_valid.
  - Output fields hold while valid & ~ready (Avalon-ST stability).
  - Latency is 1 cycle input to output. Full throughput is one beat/cycle with back-to-back packets, including alternating A/B.
- Counters: pktcount_p increments on the EOP transfer from p into the output register, wrapping 2^CNT_W-1 -> 0. Dropped orphan beats never count.
- Backpressure: aso_out_ready=0 with a full register forces space=0, so the granted ready=0. Lock and prio hold.
- Reset mid-packet: the packet is abandoned and any partial output beat is lost (valid=0). The downstream sees a packet without EOP and must tolerate it. No recovery is attempted.
- Simultaneous events in one cycle:
  - EOP transfer from A with B requesting: B is arbitrated in the next cycle (IDLE). prio is already B.
  - The orphan discard on the other input proceeds in parallel.

Decomposition:
- Shared package aso_pkg: AST_DATA_W=64, AST_EMPTY_W=3, AST_ERR_W=6, and the state enum {IDLE, LOCK_A, LOCK_B}.
- Natural sub-module: aso_out_reg, the one-stage registered Avalon-ST output slice with space generation. It is reusable for the capture writer's upstream.

Test Plan:
- Single input: A sends a 3-beat packet (empty=2 on EOP), B idle, out_ready=1.
  -> Output identical one cycle later, channel=0, pktcount_a=1, no errors.
- Contention: A and B both assert SOP in the same cycle after reset with INIT_PRIO=0, each sending 2 packets of 4 beats.
  -> Output order is A,B,A,B with no interleaving within a packet and no idle cycles between packets.
  -> pktcount_a=2, pktcount_b=2.
- Backpressure: out_ready toggles 1,0,0,1 during a 5-beat B packet.
  -> Each beat appears exactly once and is held stable while ready=0.
  -> asi_b_ready=0 on stall cycles; lock stays with B.
- Single-beat packets: A and B send continuous SOP&EOP beats.
  -> Strict alternation of channel 0/1, one beat per cycle, state remains IDLE.
  -> After 10 beats each, pktcount_a=10, pktcount_b=10.
- Protocol errors: B drives a non-SOP valid beat while A is locked; A then sends SOP mid-packet.
  -> B beat dropped, err_orphan=2'b10.
  -> A beat forwarded, err_dupsop=2'b01, A packet completes normally.
- Reset mid-packet: assert reset_n=0 on beat 2 of a 4-beat A packet.
  -> aso_out_valid=0, readys=0, counters=0 immediately.
  -> After release, a new B packet is forwarded correctly.
